sevenseg_scan: RTL and testbench
================================

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100_000, is the clk_100MHz cycles per digit slot (4 slots = 1 frame, 250 Hz frame rate at default).
REQ-002 Parameter BLANK_CYCLES, default 1_000, is the anti-ghosting gap at the start of each slot; legal range is 1 <= BLANK_CYCLES < REFRESH_DIV.
REQ-003 clk_100MHz  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high = scan display; low = display dark.
REQ-006 digit0, digit1, digit2, digit3  input  4 each  BCD/hex value per position; digit0 is rightmost.
REQ-007 dp_en  input  4  decimal-point request per position; bit i maps to digit i.
REQ-008 blank_lz  input  1  high = suppress leading zeros.
REQ-009 an  output  4  active-low anode select; bit i maps to digit i.
REQ-010 seg  output  7  active-low cathodes {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  active-low decimal point.
REQ-012 frame_tick  output  1  single-cycle pulse at each frame start.

Function
REQ-013 FSM states SHALL be IDLE, BLANK and DRIVE.
REQ-014 IDLE -> BLANK when enable=1; any state -> IDLE on the cycle after enable=0, which also clears the slot counter and the scan index.
REQ-015 BLANK SHALL last BLANK_CYCLES cycles, then go to DRIVE.
REQ-016 DRIVE SHALL last REFRESH_DIV-BLANK_CYCLES cycles, then go to BLANK with scan index incremented modulo 4.
REQ-017 Scan order SHALL be index 0,1,2,3,0...
REQ-018 On every entry to BLANK with index 0, digit0..3, dp_en and blank_lz SHALL be snapshotted together and frame_tick pulsed for exactly one cycle.
REQ-019 Displayed values SHALL come only from the snapshot; input changes mid-frame take effect at the next frame_tick.
REQ-020 an, seg and dp SHALL be registered outputs that lag the FSM state by one cycle.
REQ-021 In IDLE and BLANK: an=4'b1111, seg=7'b1111111, dp=1.
REQ-022 In DRIVE: an has only bit[index] low; seg carries the hex glyph of the snapshot digit; dp = ~dp_en[index].
REQ-023 Glyphs 0-F SHALL be the standard hex set, e.g. 0=1000000, 5=0010010, A=0001000.
REQ-024 Leading-zero blanking (snapshot blank_lz=1) rules:
  - digit3 blanked if 0;
  - digit2 blanked if 0 and digit3 blanked;
  - digit1 blanked if 0 and digit2 blanked;
  - digit0 never blanked.
REQ-025 A blanked position SHALL hold an bit high for its whole slot, with slot timing unchanged.
REQ-026 A blanked position SHALL suppress its dp.
REQ-027 Width rules: the slot counter is $clog2(REFRESH_DIV) bits; the index is 2 bits and wraps 3->0 with no extra cycle.

Reset
REQ-028 While reset_n=0: state=IDLE, index=0, counter=0, snapshot=0, an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
REQ-029 Reset asserted mid-operation SHALL darken outputs asynchronously.
REQ-030 After reset_n rises with enable=1, the first clock edge SHALL enter BLANK index 0 with frame_tick.

Structure
REQ-031 sevenseg_pkg SHALL hold the state enum and the 16 glyph constants.
REQ-032 A combinational sub-module sevenseg_decode (4-bit in, 7-bit active-low out) SHALL do glyph lookup.
REQ-033 No other sub-modules.

Verification (REFRESH_DIV=10, BLANK_CYCLES=2)
REQ-034 Reset held, enable=1 -> an=1111, seg=1111111, dp=1, frame_tick=0 throughout.
REQ-035 Digits 3,2,1,0 = 0,0,0,0, blank_lz=0 -> an sequence 1110,1101,1011,0111; each low 8 cycles with a 2-cycle all-high gap; seg=1000000; frame_tick every 40 cycles.
REQ-036 Digits (d3..d0)=(0,0,5,0), blank_lz=1, dp_en=0010 -> an[3], an[2] never low; slot 1 seg=0010010 with dp=0; slot 0 seg=1000000 with dp=1.
REQ-037 digit0 changed 3->A mid-frame -> seg stays 0110000 until after the next frame_tick, then 0001000.
REQ-038 enable dropped during DRIVE index 2 -> outputs dark one cycle later; re-enable -> frame_tick and index 0 slot first.
REQ-039 reset_n pulsed low mid-DRIVE -> an=1111 immediately without a clock edge; restart per REQ-030.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and glyph table for the four-digit seven-segment scanner.
// All glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex-to-glyph lookup, active-low cathodes {g,f,e,d,c,b,a}.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (value)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for a four-digit common-anode display with a blanking
// gap per slot, frame-synchronous input snapshot and leading-zero suppression.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_en,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

  scan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       idx, idx_next;
  logic             frame_start;

  logic [3:0][3:0]  snap_digits;
  logic [3:0]       snap_dp;
  logic             snap_lz;

  logic [3:0]       lz_blank;
  logic [6:0]       glyph;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  // One counter spans the whole slot: BLANK covers the first BLANK_CYCLES
  // counts, DRIVE the rest, so slot length is exactly REFRESH_DIV.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = idx;
    frame_start = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next  = BLANK;
          cnt_next    = '0;
          idx_next    = '0;
          frame_start = 1'b1;
        end
        BLANK: begin
          cnt_next = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_next = DRIVE;
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            state_next  = BLANK;
            cnt_next    = '0;
            idx_next    = idx + 1'b1;
            frame_start = (idx == 2'd3);
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      frame_tick <= frame_start;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
    end else if (frame_start) begin
      snap_digits <= {digit3, digit2, digit1, digit0};
      snap_dp     <= dp_en;
      snap_lz     <= blank_lz;
    end
  end

  // Leading-zero suppression cascades from the leftmost position down.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = snap_lz && (snap_digits[3] == 4'h0);
    lz_blank[2] = lz_blank[3] && (snap_digits[2] == 4'h0);
    lz_blank[1] = lz_blank[2] && (snap_digits[1] == 4'h0);
  end

  sevenseg_decode u_decode (
    .value (snap_digits[idx]),
    .seg   (glyph)
  );

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (state == DRIVE && !lz_blank[idx]) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = glyph;
      dp_next  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan with REFRESH_DIV=10, BLANK_CYCLES=2:
// stimulus queues the expected visible slots, a monitor checks each slot start.
module tb_sevenseg_scan;

  localparam int RD = 10;
  localparam int BC = 2;

  logic       clk_100MHz;
  logic       reset_n;
  logic       enable;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp_en;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t      exp_q[$];
  int         checks;
  int         errors;
  int         low_cnt[4];
  int         cyc;
  int         dark_bad;
  logic [3:0] prev_an;
  slot_t      mon_exp;

  sevenseg_scan #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .enable     (enable),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .dp_en      (dp_en),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] d3, input logic [3:0] d2,
                                input logic [3:0] d1, input logic [3:0] d0,
                                input logic [3:0] dpe, input logic lz);
    digit3   = d3;
    digit2   = d2;
    digit1   = d1;
    digit0   = d0;
    dp_en    = dpe;
    blank_lz = lz;
  endtask

  task automatic expect_slot(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_q.push_back(slot_t'{an: a, seg: s, dp: d});
  endtask

  task automatic wait_tick(output int cycles);
    bit found;
    found  = 1'b0;
    cycles = -1;
    for (int i = 0; i < 4; i++) low_cnt[i] = 0;
    for (int k = 1; k <= 200 && !found; k++) begin
      @(negedge clk_100MHz);
      for (int i = 0; i < 4; i++) if (!an[i]) low_cnt[i]++;
      if (frame_tick) begin
        cycles = k;
        found  = 1'b1;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_tick_timeout: actual=no tick required=tick within 200 cycles");
    end
  endtask

  // Monitor: each dark-to-lit transition of the anodes is one displayed slot.
  initial prev_an = 4'b1111;
  always @(negedge clk_100MHz) begin
    if (an != 4'b1111 && prev_an == 4'b1111) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_slot: actual an=%b seg=%b dp=%b required=no slot",
                 an, seg, dp);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("slot_an",  32'(an),  32'(mon_exp.an));
        check_output("slot_seg", 32'(seg), 32'(mon_exp.seg));
        check_output("slot_dp",  32'(dp),  32'(mon_exp.dp));
      end
    end
    prev_an = an;
  end

  initial begin
    #100_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    enable   = 1'b1;
    apply_stimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0);

    // Held in reset with enable high: everything dark.
    repeat (5) begin
      @(negedge clk_100MHz);
      check_output("reset_dark", 32'({an, seg, dp, frame_tick}),
                   32'({4'b1111, 7'b1111111, 1'b1, 1'b0}));
    end

    // Frame 1: all zeros, no suppression.
    expect_slot(4'b1110, 7'b1000000, 1'b1);
    expect_slot(4'b1101, 7'b1000000, 1'b1);
    expect_slot(4'b1011, 7'b1000000, 1'b1);
    expect_slot(4'b0111, 7'b1000000, 1'b1);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    @(negedge clk_100MHz);
    check_output("first_tick_after_reset", 32'(frame_tick), 32'd1);

    wait_tick(cyc);
    check_output("frame_period", cyc, 32'd40);
    for (int i = 0; i < 4; i++) check_output("slot_low_len", low_cnt[i], 32'd8);

    // Frame 2 repeats the zeros; next inputs exercise suppression and dp.
    check_output("queue_drained", exp_q.size(), 32'd0);
    expect_slot(4'b1110, 7'b1000000, 1'b1);
    expect_slot(4'b1101, 7'b1000000, 1'b1);
    expect_slot(4'b1011, 7'b1000000, 1'b1);
    expect_slot(4'b0111, 7'b1000000, 1'b1);
    apply_stimulus(4'h0, 4'h0, 4'h5, 4'h0, 4'b0010, 1'b1);

    wait_tick(cyc);
    check_output("frame_period", cyc, 32'd40);
    check_output("queue_drained", exp_q.size(), 32'd0);
    expect_slot(4'b1110, 7'b1000000, 1'b1);
    expect_slot(4'b1101, 7'b0010010, 1'b0);
    apply_stimulus(4'h0, 4'h0, 4'h0, 4'h3, 4'b0000, 1'b0);

    wait_tick(cyc);
    check_output("blank_an3_low_cycles", low_cnt[3], 32'd0);
    check_output("blank_an2_low_cycles", low_cnt[2], 32'd0);
    check_output("shown_an1_low_cycles", low_cnt[1], 32'd8);
    check_output("queue_drained", exp_q.size(), 32'd0);
    expect_slot(4'b1110, 7'b0110000, 1'b1);
    expect_slot(4'b1101, 7'b1000000, 1'b1);
    expect_slot(4'b1011, 7'b1000000, 1'b1);
    expect_slot(4'b0111, 7'b1000000, 1'b1);

    // Change digit0 before slot 0 lights: must not show until next frame.
    repeat (2) @(negedge clk_100MHz);
    digit0 = 4'hA;

    wait_tick(cyc);
    check_output("queue_drained", exp_q.size(), 32'd0);
    expect_slot(4'b1110, 7'b0001000, 1'b1);
    expect_slot(4'b1101, 7'b1000000, 1'b1);
    expect_slot(4'b1011, 7'b1000000, 1'b1);

    // Drop enable three cycles into the index-2 drive phase.
    repeat (25) @(negedge clk_100MHz);
    enable = 1'b0;
    @(negedge clk_100MHz);
    check_output("an_lag_after_disable", 32'(an), 32'(4'b1011));
    @(negedge clk_100MHz);
    check_output("dark_after_disable", 32'({an, seg, dp, frame_tick}),
                 32'({4'b1111, 7'b1111111, 1'b1, 1'b0}));
    dark_bad = 0;
    repeat (5) begin
      @(negedge clk_100MHz);
      if (an != 4'b1111 || frame_tick) dark_bad++;
    end
    check_output("stay_dark_while_disabled", dark_bad, 32'd0);
    check_output("queue_drained", exp_q.size(), 32'd0);

    enable = 1'b1;
    expect_slot(4'b1110, 7'b0001000, 1'b1);
    @(negedge clk_100MHz);
    check_output("tick_on_reenable", 32'(frame_tick), 32'd1);

    // Asynchronous reset in the middle of slot 0 drive.
    repeat (5) @(negedge clk_100MHz);
    check_output("mid_drive_before_reset", 32'(an), 32'(4'b1110));
    reset_n = 1'b0;
    #1;
    check_output("async_reset_dark", 32'({an, seg, dp, frame_tick}),
                 32'({4'b1111, 7'b1111111, 1'b1, 1'b0}));
    check_output("queue_drained", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk_100MHz);
    reset_n = 1'b1;
    expect_slot(4'b1110, 7'b0001000, 1'b1);
    expect_slot(4'b1101, 7'b1000000, 1'b1);
    expect_slot(4'b1011, 7'b1000000, 1'b1);
    expect_slot(4'b0111, 7'b1000000, 1'b1);
    @(negedge clk_100MHz);
    check_output("tick_after_reset_release", 32'(frame_tick), 32'd1);
    wait_tick(cyc);
    check_output("frame_period", cyc, 32'd40);
    check_output("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
